// File: rtl/inert_intf.sv
// Inertial sensor front end: sequences SPI configuration writes, then one
// 8-byte read burst per data-ready interrupt, publishing four signed words.
module inert_intf #(
   parameter int STARTUP_BITS = 16,
   parameter bit FAST_SIM     = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               INT,
   input  logic               done,
   input  logic [15:0]        rd_data,
   output logic               wrt,
   output logic [15:0]        cmd,
   output logic               vld,
   output logic signed [15:0] roll_rt,
   output logic signed [15:0] yaw_rt,
   output logic signed [15:0] AY,
   output logic signed [15:0] AZ
);

   localparam int CNT_W = FAST_SIM ? 8 : STARTUP_BITS;

   typedef enum logic [2:0] {WAIT_PWR, CFG, IDLE, READ, PUBLISH} state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] pwr_cnt;
   logic             int_ff1, int_ff2;
   logic             pending;
   logic [2:0]       idx;
   logic [7:0]       hold [0:7];
   logic             issue, finish, last_xfer;
   logic [3:0]       reg_addr;
   logic [15:0]      next_cmd;
   logic             unused_rd_hi;

   assign unused_rd_hi = &{1'b0, rd_data[15:8]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_ff1 <= 1'b0;
         int_ff2 <= 1'b0;
      end else begin
         int_ff1 <= INT;
         int_ff2 <= int_ff1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_PWR;
      else        state <= next_state;
   end

   // A transaction is started only when none is pending; a done with nothing
   // pending never reaches the sequencing logic.
   always_comb begin
      next_state = state;
      issue      = 1'b0;
      finish     = pending & done;
      last_xfer  = 1'b0;
      next_cmd   = 16'h0000;
      reg_addr   = (idx[2] ? 4'hA : 4'h4) + {2'b00, idx[1:0]};
      case (state)
         WAIT_PWR: begin
            if (&pwr_cnt) next_state = CFG;
         end
         CFG: begin
            case (idx[1:0])
               2'd0:    next_cmd = 16'h0D02;
               2'd1:    next_cmd = 16'h1053;
               2'd2:    next_cmd = 16'h1150;
               default: next_cmd = 16'h1460;
            endcase
            issue     = ~pending;
            last_xfer = (idx == 3'd3);
            if (finish && last_xfer) next_state = IDLE;
         end
         IDLE: begin
            if (int_ff2) next_state = READ;
         end
         READ: begin
            next_cmd  = {4'hA, reg_addr, 8'h00};
            issue     = ~pending;
            last_xfer = (idx == 3'd7);
            if (finish && last_xfer) next_state = PUBLISH;
         end
         PUBLISH: begin
            next_state = IDLE;
         end
         default: begin
            next_state = WAIT_PWR;
         end
      endcase
   end

   // The last byte is taken straight from rd_data so all four words and vld
   // appear together in the PUBLISH cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwr_cnt <= '0;
         pending <= 1'b0;
         idx     <= 3'd0;
         wrt     <= 1'b0;
         cmd     <= 16'h0000;
         vld     <= 1'b0;
         roll_rt <= '0;
         yaw_rt  <= '0;
         AY      <= '0;
         AZ      <= '0;
         for (int i = 0; i < 8; i++) hold[i] <= 8'h00;
      end else begin
         wrt <= 1'b0;
         vld <= 1'b0;
         if (state == WAIT_PWR) pwr_cnt <= pwr_cnt + 1'b1;
         if (state == IDLE) idx <= 3'd0;
         if (issue) begin
            wrt     <= 1'b1;
            cmd     <= next_cmd;
            pending <= 1'b1;
         end
         if (finish) begin
            pending <= 1'b0;
            idx     <= idx + 3'd1;
            if (state == READ) hold[idx] <= rd_data[7:0];
         end
         if (state == READ && finish && last_xfer) begin
            roll_rt <= {hold[1], hold[0]};
            yaw_rt  <= {hold[3], hold[2]};
            AY      <= {hold[5], hold[4]};
            AZ      <= {rd_data[7:0], hold[6]};
            vld     <= 1'b1;
         end
      end
   end

endmodule
